// File: rtl/msrv32_pc_fetch_unit.sv
// Program counter and instruction-fetch request stage.
// Holds the fetch address stable under back-pressure and remembers late redirects.
module msrv32_pc_fetch_unit #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic [1:0]  pc_src_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        fetch_ready_in,
    output logic        fetch_valid_out,
    output logic [31:0] i_addr_out,
    output logic [31:0] pc_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    localparam logic [0:0] ST_RST = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic        redir_pending_q, redir_pending_d;
    logic        flush_q, flush_d;

    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
    logic        accept;
    logic        unused_low_bits;

    assign unused_low_bits = ^{epc_in[1:0], trap_address_in[1:0], iadder_in[0]};

    always_comb begin
        target = BOOT_ADDRESS;
        unique case (pc_src_in)
            2'b00: target = BOOT_ADDRESS;
            2'b01: target = {epc_in[31:2], 2'b00};
            2'b10: target = {trap_address_in[31:2], 2'b00};
            2'b11: target = {iadder_in[31:1], 1'b0};
        endcase
    end

    // A misaligned jump target is flagged but never loaded into the PC.
    assign misaligned = (pc_src_in == 2'b11) & branch_taken_in & iadder_in[1];
    assign redirect   = (pc_src_in != 2'b11) | (branch_taken_in & ~misaligned);
    assign accept     = (state_q == ST_RUN) & fetch_ready_in;

    always_comb begin
        state_d         = ST_RUN;
        i_addr_d        = i_addr_q;
        pc_d            = pc_q;
        redir_addr_d    = redir_addr_q;
        redir_pending_d = redir_pending_q;
        flush_d         = flush_q;
        if (accept) begin
            pc_d            = i_addr_q;
            redir_pending_d = 1'b0;
            if (redirect) begin
                i_addr_d = target;
            end else if (redir_pending_q) begin
                i_addr_d = redir_addr_q;
            end else begin
                i_addr_d = i_addr_q + 32'd4;
            end
        end else if (redirect) begin
            redir_pending_d = 1'b1;
            redir_addr_d    = target;
        end
        // Flush stays up while stalled until an accept on a clean path.
        if (redirect | misaligned | redir_pending_q) begin
            flush_d = 1'b1;
        end else if (accept) begin
            flush_d = 1'b0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q         <= ST_RST;
            i_addr_q        <= BOOT_ADDRESS;
            pc_q            <= BOOT_ADDRESS;
            redir_addr_q    <= 32'h0;
            redir_pending_q <= 1'b0;
            flush_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            i_addr_q        <= i_addr_d;
            pc_q            <= pc_d;
            redir_addr_q    <= redir_addr_d;
            redir_pending_q <= redir_pending_d;
            flush_q         <= flush_d;
        end
    end

    assign fetch_valid_out      = (state_q == ST_RUN);
    assign i_addr_out           = i_addr_q;
    assign pc_out               = pc_q;
    assign flush_out            = flush_q;
    assign misaligned_instr_out = misaligned;

endmodule
